// File: rtl/edge_event_scheduler.sv
// Multi-channel edge event scheduler: per-channel edge detection with coalescing
// pending slots, shared through a round-robin arbiter onto one registered valid/ready port.
module edge_event_scheduler #(
    parameter int CHANNELS = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_low,
    input  logic [CHANNELS-1:0] level,
    input  logic [CHANNELS-1:0] pos_enable,
    input  logic [CHANNELS-1:0] neg_enable,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [CW-1:0]       event_channel,
    output logic                event_rising,
    output logic [CHANNELS-1:0] overflow,
    input  logic [CHANNELS-1:0] overflow_clear,
    output logic                busy
);

    logic [CHANNELS-1:0] r_previous;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_pend_rise;
    logic [CHANNELS-1:0] r_overflow;
    logic [CW-1:0]       r_last_grant;
    logic                r_valid;
    logic [CW-1:0]       r_channel;
    logic                r_rising;

    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic [CHANNELS-1:0] w_edge;
    logic [CHANNELS-1:0] w_grant;
    logic [CHANNELS-1:0] w_coalesce;
    logic                w_load;
    logic                w_found_hi;
    logic                w_found_lo;
    logic [CW-1:0]       w_idx_hi;
    logic [CW-1:0]       w_idx_lo;
    logic                w_rise_hi;
    logic                w_rise_lo;
    logic                w_found;
    logic [CW-1:0]       w_gnt_idx;
    logic                w_gnt_rise;

    assign w_rise     = level & ~r_previous & pos_enable;
    assign w_fall     = ~level & r_previous & neg_enable;
    assign w_edge     = w_rise | w_fall;
    assign w_load     = !r_valid || event_ready;
    // A channel granted this cycle hands its old event out, so a fresh edge there is not a coalesce.
    assign w_coalesce = w_edge & r_pending & ~w_grant;

    // Round-robin: first pending index above last_grant wins, else wrap to the lowest pending.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_idx_hi   = '0;
        w_idx_lo   = '0;
        w_rise_hi  = 1'b0;
        w_rise_lo  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_pending[i]) begin
                if (i > int'(r_last_grant)) begin
                    if (!w_found_hi) begin
                        w_found_hi = 1'b1;
                        w_idx_hi   = CW'(i);
                        w_rise_hi  = r_pend_rise[i];
                    end
                end else if (!w_found_lo) begin
                    w_found_lo = 1'b1;
                    w_idx_lo   = CW'(i);
                    w_rise_lo  = r_pend_rise[i];
                end
            end
        end
        w_found    = w_found_hi | w_found_lo;
        w_gnt_idx  = w_found_hi ? w_idx_hi  : w_idx_lo;
        w_gnt_rise = w_found_hi ? w_rise_hi : w_rise_lo;
    end

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_grant[i] = w_load && w_found && (w_gnt_idx == CW'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_previous   <= '0;
            r_pending    <= '0;
            r_pend_rise  <= '0;
            r_overflow   <= '0;
            r_last_grant <= CW'(CHANNELS - 1);
            r_valid      <= 1'b0;
            r_channel    <= '0;
            r_rising     <= 1'b0;
        end else begin
            r_previous  <= level;
            r_pending   <= w_edge | (r_pending & ~w_grant);
            r_pend_rise <= w_rise | (~w_edge & r_pend_rise);
            r_overflow  <= (r_overflow & ~overflow_clear) | w_coalesce;
            if (w_load) begin
                r_valid <= w_found;
                if (w_found) begin
                    r_channel    <= w_gnt_idx;
                    r_rising     <= w_gnt_rise;
                    r_last_grant <= w_gnt_idx;
                end
            end
        end
    end

    assign event_valid   = r_valid;
    assign event_channel = r_channel;
    assign event_rising  = r_rising;
    assign overflow      = r_overflow;
    assign busy          = (|r_pending) | r_valid;

endmodule
